// File: rtl/hdlc_pkg.sv
// Shared HDLC framing constants, FSM state encoding and a bit-reversal helper.
package hdlc_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        OPEN_FLAG  = 3'd1,
        DATA       = 3'd2,
        FCS        = 3'd3,
        CLOSE_FLAG = 3'd4,
        ABORT      = 3'd5
    } hdlc_state_e;

    localparam logic [7:0]  FLAG        = 8'h7E;
    localparam logic [7:0]  ABORT_PAT   = 8'h7F;
    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [2:0]  STUFF_LIMIT = 3'd5;

    // The line is LSB first, so the CRC runs on the bit-reversed polynomial.
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hdlc_fcs_gen.sv
// Serial CRC-16-CCITT (reflected) register; one payload bit per enabled cycle.
module hdlc_fcs_gen
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    localparam logic [15:0] POLY_REFL = reflect16(CRC_POLY);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ din) ? POLY_REFL : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening/closing flags, zero insertion, optional FCS, abort sequence.
// Handshake: a byte is taken on a clock edge where Tx_Valid and Tx_Ready are both high.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int FCS_EN = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Tx_Enable,
    input  logic [7:0]  Tx_Data,
    input  logic        Tx_Valid,
    input  logic        Tx_Last,
    output logic        Tx_Ready,
    input  logic        Tx_AbortFrame,
    output logic        Tx,
    output logic        Tx_Busy,
    output logic        Tx_Done,
    output logic        Tx_AbortedTrans,
    output hdlc_state_e Dbg_State
);

    hdlc_state_e state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  ones_q, ones_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  abort_wait_q, abort_wait_d;
    logic        last_q, last_d;
    logic        fcs_hi_q, fcs_hi_d;
    logic        tail_q, tail_d;
    logic        abort_pend_q, abort_pend_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic [15:0] crc;
    logic [15:0] fcs_word;
    logic        stuffing_state, stuff_slot, tx_bit, byte_end;
    logic        abort_req, abort_now, enter_abort, crc_en, crc_clr;

    hdlc_fcs_gen u_fcs_gen (
        .clk (Clk),
        .rst (Rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (tx_bit),
        .crc (crc)
    );

    // Line bit for the current cycle; a stuff slot sends 0 without advancing the byte.
    always_comb begin
        stuffing_state = (state_q == DATA) || (state_q == FCS);
        stuff_slot     = stuffing_state && (ones_q == STUFF_LIMIT);
        fcs_word       = ~crc;
        case (state_q)
            OPEN_FLAG, CLOSE_FLAG: tx_bit = FLAG[bit_cnt_q];
            DATA:                  tx_bit = stuff_slot ? 1'b0 : data_q[bit_cnt_q];
            FCS:                   tx_bit = stuff_slot ? 1'b0 : fcs_word[{fcs_hi_q, bit_cnt_q}];
            ABORT:                 tx_bit = ABORT_PAT[bit_cnt_q];
            default:               tx_bit = 1'b1;
        endcase
        byte_end  = (bit_cnt_q == 3'd7) && !stuff_slot;
        crc_clr   = (state_q == IDLE);
        crc_en    = (state_q == DATA) && !stuff_slot;
        Tx_Ready  = !abort_pend_q && byte_end &&
                    ((state_q == OPEN_FLAG) || ((state_q == DATA) && !last_q));
        abort_req = (abort_pend_q || Tx_AbortFrame) && (state_q != IDLE) && (state_q != ABORT);
        // Flags abort on the next bit; bytes wait for their boundary, bounded by the wait counter.
        abort_now = abort_req && ((state_q == OPEN_FLAG) || (state_q == CLOSE_FLAG) ||
                    byte_end || tail_q || (abort_pend_q && (abort_wait_q == 3'd6)));
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        last_d       = last_q;
        fcs_hi_d     = fcs_hi_q;
        tail_d       = tail_q;
        abort_pend_d = abort_pend_q;
        abort_wait_d = abort_wait_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        ones_d       = stuffing_state ? (tx_bit ? ones_q + 3'd1 : 3'd0) : 3'd0;
        enter_abort  = abort_now || (Tx_Ready && !Tx_Valid);

        if (abort_req) begin
            abort_pend_d = 1'b1;
            abort_wait_d = abort_pend_q ? abort_wait_q + 3'd1 : 3'd0;
        end
        if (Tx_Ready && Tx_Valid) begin
            data_d = Tx_Data;
            last_d = Tx_Last;
        end

        case (state_q)
            IDLE: begin
                if (Tx_Enable && !done_q) begin
                    state_d   = OPEN_FLAG;
                    bit_cnt_d = 3'd0;
                    last_d    = 1'b0;
                    tail_d    = 1'b0;
                end
            end
            OPEN_FLAG: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_end) begin
                    state_d = DATA;
                end
            end
            DATA, FCS: begin
                if (stuff_slot) begin
                    if (tail_q) begin
                        state_d = CLOSE_FLAG;
                        tail_d  = 1'b0;
                        ones_d  = 3'd0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if ((state_q == DATA) && last_q && (FCS_EN != 0)) begin
                            state_d  = FCS;
                            fcs_hi_d = 1'b0;
                        end else if ((state_q == FCS) && !fcs_hi_q) begin
                            fcs_hi_d = 1'b1;
                        end else if (last_q || (state_q == FCS)) begin
                            // A body ending in five 1s still owes one inserted 0 before the flag.
                            if (ones_d == STUFF_LIMIT) begin
                                tail_d = 1'b1;
                            end else begin
                                state_d = CLOSE_FLAG;
                                ones_d  = 3'd0;
                            end
                        end
                    end
                end
            end
            CLOSE_FLAG: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ABORT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_abort) begin
            state_d      = ABORT;
            bit_cnt_d    = 3'd0;
            ones_d       = 3'd0;
            tail_d       = 1'b0;
            abort_pend_d = 1'b0;
            abort_wait_d = 3'd0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            ones_q       <= 3'd0;
            data_q       <= 8'h00;
            last_q       <= 1'b0;
            fcs_hi_q     <= 1'b0;
            tail_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            abort_wait_q <= 3'd0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_q       <= ones_d;
            data_q       <= data_d;
            last_q       <= last_d;
            fcs_hi_q     <= fcs_hi_d;
            tail_q       <= tail_d;
            abort_pend_q <= abort_pend_d;
            abort_wait_q <= abort_wait_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign Tx              = tx_bit;
    assign Tx_Busy         = (state_q != IDLE);
    assign Tx_Done         = done_q;
    assign Tx_AbortedTrans = aborted_q;
    assign Dbg_State       = state_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: captures the serial line per frame and checks it bit-exact.
module tb_hdlc_tx_framer;
    import hdlc_pkg::*;

    logic        Clk, Rst, Tx_Enable, Tx_Valid, Tx_Last, Tx_AbortFrame;
    logic [7:0]  Tx_Data;
    logic        Tx_Ready, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans;
    hdlc_state_e Dbg_State;

    hdlc_tx_framer #(.FCS_EN(1)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Tx_Enable       (Tx_Enable),
        .Tx_Data         (Tx_Data),
        .Tx_Valid        (Tx_Valid),
        .Tx_Last         (Tx_Last),
        .Tx_Ready        (Tx_Ready),
        .Tx_AbortFrame   (Tx_AbortFrame),
        .Tx              (Tx),
        .Tx_Busy         (Tx_Busy),
        .Tx_Done         (Tx_Done),
        .Tx_AbortedTrans (Tx_AbortedTrans),
        .Dbg_State       (Dbg_State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  pay [16];
    logic        line_q [$];
    logic        exp_q [$];
    logic        dq [$];
    int          exp_ones, d_ones, done_cnt, abt_cnt, bad_cnt;
    logic        fin;
    logic [7:0]  fcs_lo, fcs_hi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_flag(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_ones = 0;
    endtask

    task automatic exp_data(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            exp_ones = b[i] ? exp_ones + 1 : 0;
            if (exp_ones == 5) begin
                exp_q.push_back(1'b0);
                exp_ones = 0;
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        int first_bad;
        first_bad = -1;
        check({tag, "_len"}, line_q.size(), exp_q.size());
        for (int i = 0; i < line_q.size() && i < exp_q.size(); i++) begin
            if (line_q[i] !== exp_q[i] && first_bad < 0) first_bad = i;
        end
        check({tag, "_first_bad_bit"}, first_bad, -1);
    endtask

    task automatic load_byte(input int idx, input int n_valid, input bit with_last);
        if (idx < n_valid) begin
            Tx_Valid = 1'b1;
            Tx_Data  = pay[idx];
            Tx_Last  = with_last && (idx == n_valid - 1);
        end else begin
            Tx_Valid = 1'b0;
            Tx_Data  = 8'h00;
            Tx_Last  = 1'b0;
        end
    endtask

    // Drives one frame and records every line bit while busy, until Done/Aborted or budget.
    task automatic run_frame(input int n_valid, input bit with_last, input int abort_after,
                             input bit hold_en);
        int  accepted;
        bit  took;
        line_q.delete();
        exp_q.delete();
        done_cnt = 0;
        abt_cnt  = 0;
        accepted = 0;
        fin      = 1'b0;
        @(posedge Clk); #1;
        Tx_Enable = 1'b1;
        load_byte(0, n_valid, with_last);
        @(posedge Clk); #1;
        Tx_Enable = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge Clk);
            if (Tx_Busy) line_q.push_back(Tx);
            if (Tx_Done) done_cnt++;
            if (Tx_AbortedTrans) abt_cnt++;
            took = Tx_Ready && Tx_Valid;
            fin  = Tx_Done || Tx_AbortedTrans;
            @(posedge Clk); #1;
            Tx_AbortFrame = 1'b0;
            if (took) begin
                accepted++;
                load_byte(accepted, n_valid, with_last);
                if (accepted == abort_after) Tx_AbortFrame = 1'b1;
            end
            Tx_Enable = hold_en && (accepted >= 1) && !fin;
            if (fin) break;
        end
        Tx_Enable = 1'b0;
        check("frame_completed_in_budget", fin, 1'b1);
    endtask

    initial begin
        Rst = 1'b1; Tx_Enable = 1'b0; Tx_Data = 8'h00; Tx_Valid = 1'b0;
        Tx_Last = 1'b0; Tx_AbortFrame = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_tx", Tx, 1'b1);
        check("reset_ready", Tx_Ready, 1'b0);
        check("reset_busy", Tx_Busy, 1'b0);
        check("reset_done", Tx_Done, 1'b0);
        check("reset_aborted", Tx_AbortedTrans, 1'b0);
        check("reset_state", Dbg_State, IDLE);
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);

        // Single 0x00 byte; FCS = 0xF078. Tx_Enable held through Done must be ignored.
        pay[0] = 8'h00;
        run_frame(1, 1'b1, 0, 1'b1);
        exp_flag(FLAG); exp_data(8'h00); exp_data(8'h78); exp_data(8'hF0); exp_flag(FLAG);
        compare_stream("byte00");
        check("byte00_done_pulses", done_cnt, 1);
        check("byte00_abort_pulses", abt_cnt, 0);
        @(negedge Clk);
        check("enable_with_done_ignored_busy", Tx_Busy, 1'b0);
        check("enable_with_done_ignored_tx", Tx, 1'b1);
        repeat (3) @(posedge Clk);

        // "123456789": standard check value gives FCS bytes 0x6E, 0x90 on the line.
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        run_frame(9, 1'b1, 0, 1'b0);
        exp_flag(FLAG);
        for (int i = 0; i < 9; i++) exp_data(pay[i]);
        exp_data(8'h6E); exp_data(8'h90); exp_flag(FLAG);
        compare_stream("ascii9");
        check("ascii9_done_pulses", done_cnt, 1);
        dq.delete();
        d_ones = 0;
        for (int i = 8; i < line_q.size() - 8; i++) begin
            if (d_ones == 5) begin
                d_ones = 0;
            end else begin
                dq.push_back(line_q[i]);
                d_ones = line_q[i] ? d_ones + 1 : 0;
            end
        end
        fcs_lo = 8'h00;
        fcs_hi = 8'h00;
        if (dq.size() >= 16) begin
            for (int k = 0; k < 8; k++) begin
                fcs_lo[k] = dq[dq.size() - 16 + k];
                fcs_hi[k] = dq[dq.size() - 8 + k];
            end
        end
        check("ascii9_fcs_low", fcs_lo, 8'h6E);
        check("ascii9_fcs_high", fcs_hi, 8'h90);
        repeat (3) @(posedge Clk);

        // 0xFF: data 11111 0 111, FCS 0xFF00 (zeros, then stuffed ones), flags never stuffed.
        pay[0] = 8'hFF;
        run_frame(1, 1'b1, 0, 1'b0);
        exp_flag(FLAG); exp_data(8'hFF); exp_data(8'h00); exp_data(8'hFF); exp_flag(FLAG);
        compare_stream("byteFF");
        check("byteFF_done_pulses", done_cnt, 1);
        repeat (3) @(posedge Clk);

        // Abort requested during the second byte: pattern follows that byte, no closing flag.
        pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h56; pay[3] = 8'h78;
        run_frame(4, 1'b0, 2, 1'b0);
        exp_flag(FLAG); exp_data(8'h12); exp_data(8'h34); exp_flag(ABORT_PAT);
        compare_stream("abort_req");
        check("abort_req_aborted_pulses", abt_cnt, 1);
        check("abort_req_done_pulses", done_cnt, 0);
        repeat (3) @(posedge Clk);

        // Underrun at the third Tx_Ready.
        run_frame(2, 1'b0, 0, 1'b0);
        exp_flag(FLAG); exp_data(8'h12); exp_data(8'h34); exp_flag(ABORT_PAT);
        compare_stream("underrun");
        check("underrun_aborted_pulses", abt_cnt, 1);
        check("underrun_done_pulses", done_cnt, 0);
        repeat (3) @(posedge Clk);

        // Reset in the middle of a 0x00 data byte.
        Tx_Data = 8'h00; Tx_Last = 1'b0; Tx_Valid = 1'b1;
        @(posedge Clk); #1;
        Tx_Enable = 1'b1;
        @(posedge Clk); #1;
        Tx_Enable = 1'b0;
        repeat (11) @(posedge Clk);
        @(negedge Clk);
        check("mid_data_tx", Tx, 1'b0);
        check("mid_data_busy", Tx_Busy, 1'b1);
        #1 Rst = 1'b1;
        #1;
        check("rst_immediate_tx", Tx, 1'b1);
        check("rst_immediate_busy", Tx_Busy, 1'b0);
        check("rst_immediate_ready", Tx_Ready, 1'b0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        Tx_Valid = 1'b0;
        bad_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || Tx_Done !== 1'b0 || Tx_AbortedTrans !== 1'b0)
                bad_cnt++;
        end
        check("post_reset_idle_cycles_bad", bad_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_framer.md
HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

Interface
REQ-001 SHALL have parameter FCS_EN, default 1, meaning append a 16-bit FCS before the closing flag when 1.
REQ-002 SHALL have port Clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Tx_Enable  input  1  single-cycle frame start request.
REQ-005 SHALL have port Tx_Data  input  8  payload byte.
REQ-006 SHALL have port Tx_Valid  input  1  Tx_Data is valid.
REQ-007 SHALL have port Tx_Last  input  1  qualifies Tx_Data as the final payload byte.
REQ-008 SHALL have port Tx_Ready  output  1  byte accepted when Tx_Valid and Tx_Ready are both high.
REQ-009 SHALL have port Tx_AbortFrame  input  1  abort the current frame.
REQ-010 SHALL have port Tx  output  1  serial line, one bit per Clk.
REQ-011 SHALL have port Tx_Busy  output  1  frame in progress.
REQ-012 SHALL have port Tx_Done  output  1  one-cycle pulse after the last closing-flag bit.
REQ-013 SHALL have port Tx_AbortedTrans  output  1  one-cycle pulse after the last abort-pattern bit.

Function
REQ-014 SHALL implement states IDLE, OPEN_FLAG, DATA, FCS, CLOSE_FLAG and ABORT.
REQ-015 In IDLE, Tx SHALL be 1; Tx_Enable SHALL move the block to OPEN_FLAG, with the first flag bit on Tx the next cycle.
REQ-016 Tx_Enable SHALL be ignored when not in IDLE.
REQ-017 The flag SHALL be 0x7E, sent LSB first (0,1,1,1,1,1,1,0), and SHALL not be bit-stuffed.
REQ-018 Bytes in DATA and FCS SHALL be shifted out LSB first.
REQ-019 Tx_Ready SHALL pulse for exactly one cycle on the last bit slot of the current byte, or on the final open-flag bit, so that there is no gap between bytes.
REQ-020 Zero insertion: after five consecutive 1s from DATA/FCS, one 0 SHALL be inserted and the shift SHALL stall one cycle.
REQ-021 The ones counter SHALL clear on any 0 sent, including an inserted 0, and on entry to any flag state.
REQ-022 Stalls SHALL delay the Tx_Ready pulse accordingly.
REQ-023 An accepted byte with Tx_Last=1 SHALL go to FCS when FCS_EN=1, otherwise to CLOSE_FLAG, after that byte completes.
REQ-024 Underrun: if Tx_Ready is high and Tx_Valid is low, the block SHALL go to ABORT.
REQ-025 FCS SHALL be CRC-16-CCITT (poly 0x1021, reflected, init 0xFFFF), computed over unstuffed payload bits; the ones-complement SHALL be sent low byte first, LSB first.
REQ-026 Tx_AbortFrame while Tx_Busy SHALL go to ABORT at the next byte/flag bit boundary, but no later than 8 cycles.
REQ-027 ABORT SHALL send 0x7F LSB first (seven 1s then 0), unstuffed, then pulse Tx_AbortedTrans and return to IDLE.
REQ-028 Abort SHALL win over simultaneous Tx_Last or FCS completion.
REQ-029 CLOSE_FLAG completion SHALL pulse Tx_Done and return to IDLE.
REQ-030 Tx_Enable asserted in the same cycle as Tx_Done SHALL be ignored.
REQ-031 Tx_Busy SHALL be high in every state except IDLE.

Reset
REQ-032 Rst SHALL immediately force state IDLE, Tx=1, Tx_Ready=0, Tx_Busy=0, Tx_Done=0 and Tx_AbortedTrans=0, and SHALL clear the ones counter, bit counter and CRC register.
REQ-033 Rst mid-frame SHALL emit no closing flag and no abort pattern; the line SHALL idle at 1.

Structure
REQ-034 Package hdlc_pkg SHALL hold the state enum, FLAG=8'h7E, ABORT_PAT=8'h7F, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF and STUFF_LIMIT=5.
REQ-035 The CRC SHALL be a sub-module hdlc_fcs_gen, with a 1-bit serial update, clear and enable.

Verification
REQ-036 Tx_Enable, then the single byte 0x00 with Last -> Tx: 01111110, 00000000, FCS, 01111110; Tx_Done pulses once.
REQ-037 ASCII "123456789" with Last on '9' -> destuffed FCS bytes on the line are 0x6E then 0x90.
REQ-038 Payload 0xFF -> bits after the open flag are 11111 0 111; no stuffing appears inside any flag.
REQ-039 Tx_AbortFrame after the 2nd byte -> 11111110 sent within 8 cycles; Tx_AbortedTrans pulses; no closing flag.
REQ-040 Tx_Valid held low at the 3rd Tx_Ready -> abort pattern sent and Tx_AbortedTrans pulses.
REQ-041 Rst mid-DATA -> Tx=1 in the same cycle; with Tx_Enable held low after release, Tx stays 1 and Tx_Busy=0.
